key_buffer: RTL and testbench
=============================

# key_buffer

Scan-code decode and key FIFO between the PS/2 keyboard receiver and the memory-mapped keyboard register. Consumes the receiver's 8-bit set-2 scan-code stream and discards break sequences (0xF0 xx) and extended sequences (0xE0 ...). Make codes, including typematic repeats, go into a small FIFO. The memory block reads the FIFO head as `pressed_key` and pops it with `clean_key_buffer`.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2
- `CLK`  in  1  CPU clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `scan_valid`  in  1  one-cycle strobe: `scan_code` holds a received byte
- `scan_code`  in  8  received PS/2 byte
- `clean_key_buffer`  in  1  one-cycle pop request from memory after a keyboard read
- `pressed_key`  out  8  FIFO head make code; 8'h00 when empty
- `key_count`  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- `overflow`  out  1  sticky: a make code was dropped because the FIFO was full

## Operation
- Decoder FSM states: IDLE, BREAK, EXT, EXT_BREAK. It advances only on `scan_valid`.
  - IDLE:
    - 0xF0 → BREAK.
    - 0xE0 → EXT.
    - 0x00 or 0xFF (receiver error/overrun codes) → stay in IDLE, byte discarded.
    - Any other byte is a make code: push it, stay in IDLE.
  - BREAK: any byte → IDLE, byte discarded (release of a key).
  - EXT:
    - 0xF0 → EXT_BREAK.
    - Any other byte → IDLE, byte discarded. Extended keys are not reported.
  - EXT_BREAK: any byte → IDLE, discarded.
- FIFO storage and pointers:
  - DEPTH × 8 register array.
  - `wr_ptr` and `rd_ptr` are each $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `key_count` is a separate counter.
- Push (decoder-generated):
  - If `key_count` < DEPTH, write at `wr_ptr`, increment `wr_ptr` and count.
  - If `key_count` == DEPTH, drop the code and set `overflow`.
- Pop (`clean_key_buffer`):
  - If `key_count` > 0, increment `rd_ptr` and decrement count.
  - If empty, the pop is ignored; there is no underflow flag.
- Push and pop in the same cycle:
  - Non-empty and not full: both happen, count unchanged.
  - Full: the pop frees a slot, so the push is accepted and `overflow` is not set.
  - Empty: the push is accepted and the pop is ignored. The new code is not consumed; count becomes 1.
- `pressed_key` = `mem[rd_ptr]` when `key_count` ≠ 0, else 8'h00. It is combinational from registered state.
- `overflow` clears only on `reset`.

## Timing
- Reset values, applied at the `CLK` edge while `reset` = 1:
  - FSM = IDLE; `wr_ptr` = `rd_ptr` = 0; `key_count` = 0; `overflow` = 0.
  - `pressed_key` therefore reads 8'h00.
  - FIFO array contents are don't-care.
- Reset mid-operation:
  - A pending 0xF0/0xE0 prefix is forgotten.
  - All queued keys are lost.
  - A `scan_valid` in the reset cycle is ignored.
- Push latency: `scan_valid` with a make code in IDLE at edge n → `key_count` and `pressed_key` updated after edge n, visible in cycle n+1. Nothing is visible at the edge itself.
- Pop latency: `clean_key_buffer` at edge n → the next head (or 8'h00) is visible in cycle n+1.
- `scan_valid` may assert on consecutive cycles; each byte is processed once.
- `clean_key_buffer` held high for k cycles pops k entries. The memory block must drive a single-cycle strobe per read.
- No ready/backpressure toward the receiver. Bytes arriving at a full FIFO are lost and flagged by `overflow`.

## Test plan
- Reset then idle:
  - `reset` for 2 cycles → `pressed_key` = 8'h00, `key_count` = 0, `overflow` = 0.
- Make/break:
  - Send 0x1C, 0xF0, 0x1C ('A' press/release) → `key_count` = 1, `pressed_key` = 8'h1C.
  - Pop once → `key_count` = 0, `pressed_key` = 8'h00.
- Extended filtering:
  - Send 0xE0, 0x75, 0xE0, 0xF0, 0x75, then 0x32 → only 0x32 queued, `key_count` = 1.
- Full / overflow / wrap (DEPTH = 8):
  - Push 0x15, 0x1D, 0x24, 0x2D, 0x2C, 0x35, 0x3C, 0x43, then 0x44 → `key_count` = 8, `overflow` = 1, head 8'h15.
  - Pop 8 → heads 0x15 … 0x43 in order, then 8'h00.
  - Push 0x4D → head 8'h4D, proving pointer wrap.
- Simultaneous events:
  - Full FIFO: `scan_valid` 0x1B with pop in the same cycle → `key_count` stays 8, `overflow` unchanged, tail is 0x1B.
  - Empty FIFO: push 0x1B with pop → `key_count` = 1, head 8'h1B.
- Reset mid-sequence:
  - Send 0xF0, assert `reset`, then send 0x1C → 0x1C queued as a make code, `key_count` = 1.

Source files
------------

// File: rtl/key_buffer.sv
// key_buffer: PS/2 set-2 scan-code decoder feeding a small make-code FIFO.
// Revision 1.0
`default_nettype none

module key_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     scan_valid,
  input  logic [7:0]               scan_code,
  input  logic                     clean_key_buffer,
  output logic [7:0]               pressed_key,
  output logic [$clog2(DEPTH):0]   key_count,
  output logic                     overflow
);

  localparam int              AW     = $clog2(DEPTH);
  localparam logic [AW:0]     C_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BREAK     = 2'd1,
    S_EXT       = 2'd2,
    S_EXT_BREAK = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic w_make;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_make  = scan_valid && (r_state == S_IDLE) &&
                   (scan_code != 8'hF0) && (scan_code != 8'hE0) &&
                   (scan_code != 8'h00) && (scan_code != 8'hFF);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_FULL);
  assign w_pop   = clean_key_buffer && !w_empty;
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign w_push  = w_make && (!w_full || w_pop);

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (scan_valid) begin
      case (r_state)
        S_IDLE: begin
          if (scan_code == 8'hF0)      r_state <= S_BREAK;
          else if (scan_code == 8'hE0) r_state <= S_EXT;
          else                         r_state <= S_IDLE;
        end
        S_EXT:   r_state <= (scan_code == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_make && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= scan_code;
  end

  assign pressed_key = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign key_count   = r_count;
  assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_key_buffer.sv
// tb_key_buffer: directed plan steps plus random traffic against a queue model.
`default_nettype none

module tb_key_buffer;

  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       clean_key_buffer = 1'b0;
  logic [7:0] pressed_key;
  logic [3:0] key_count;
  logic       overflow;

  key_buffer #(.DEPTH(DEPTH)) dut (
    .CLK              (CLK),
    .reset            (reset),
    .scan_valid       (scan_valid),
    .scan_code        (scan_code),
    .clean_key_buffer (clean_key_buffer),
    .pressed_key      (pressed_key),
    .key_count        (key_count),
    .overflow         (overflow)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] mq[$];
  int         swallow = 0;   // bytes still to be discarded after a prefix
  bit         ext = 0;       // last byte was an 0xE0 prefix
  bit         m_ovf = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic v, input logic [7:0] c, input logic p);
    bit make;
    bit do_pop;
    make = 0;
    if (r) begin
      mq.delete();
      swallow = 0;
      ext = 0;
      m_ovf = 0;
      return;
    end
    if (v) begin
      if (swallow > 0) swallow--;
      else if (ext) begin
        ext = 0;
        if (c == 8'hF0) swallow = 1;
      end
      else if (c == 8'hF0) swallow = 1;
      else if (c == 8'hE0) ext = 1;
      else if (c != 8'h00 && c != 8'hFF) make = 1;
    end
    do_pop = p && (mq.size() > 0);
    if (make) begin
      if (mq.size() < DEPTH || do_pop) mq.push_back(c);
      else m_ovf = 1;
    end
    if (do_pop) void'(mq.pop_front());
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] c, input logic p);
    reset = r;
    scan_valid = v;
    scan_code = c;
    clean_key_buffer = p;
    @(posedge CLK);
    model(r, v, c, p);
    #1;
    reset = 0;
    scan_valid = 0;
    clean_key_buffer = 0;
    chk("count", {4'h0, key_count}, 8'(mq.size()));
    chk("head", pressed_key, (mq.size() > 0) ? mq[0] : 8'h00);
    chk("ovf", {7'h0, overflow}, {7'h0, m_ovf});
  endtask

  task automatic send(input logic [7:0] c);
    cyc(0, 1, c, 0);
  endtask

  task automatic pop1();
    cyc(0, 0, 8'h00, 1);
  endtask

  initial begin
    logic [7:0] fill[9];
    logic [7:0] rc;
    fill = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    chk("rst_head", pressed_key, 8'h00);
    chk("rst_count", {4'h0, key_count}, 8'h00);
    chk("rst_ovf", {7'h0, overflow}, 8'h00);

    send(8'h1C); send(8'hF0); send(8'h1C);
    chk("a_count", {4'h0, key_count}, 8'h01);
    chk("a_head", pressed_key, 8'h1C);
    pop1();
    chk("a_popped", pressed_key, 8'h00);

    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h32);
    chk("ext_count", {4'h0, key_count}, 8'h01);
    chk("ext_head", pressed_key, 8'h32);
    pop1();

    for (int i = 0; i < 9; i++) send(fill[i]);
    chk("full_count", {4'h0, key_count}, 8'h08);
    chk("full_ovf", {7'h0, overflow}, 8'h01);
    chk("full_head", pressed_key, 8'h15);
    for (int i = 0; i < 8; i++) begin
      chk("drain_head", pressed_key, fill[i]);
      pop1();
    end
    chk("drained", pressed_key, 8'h00);
    send(8'h4D);
    chk("wrap_head", pressed_key, 8'h4D);
    pop1();

    cyc(1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) send(fill[i]);
    cyc(0, 1, 8'h1B, 1);
    chk("fullpp_count", {4'h0, key_count}, 8'h08);
    chk("fullpp_ovf", {7'h0, overflow}, 8'h00);
    for (int i = 0; i < 7; i++) pop1();
    chk("fullpp_tail", pressed_key, 8'h1B);
    pop1();
    cyc(0, 1, 8'h1B, 1);
    chk("emptypp_count", {4'h0, key_count}, 8'h01);
    chk("emptypp_head", pressed_key, 8'h1B);

    send(8'hF0);
    cyc(1, 1, 8'h77, 0);
    send(8'h1C);
    chk("rstmid_count", {4'h0, key_count}, 8'h01);
    chk("rstmid_head", pressed_key, 8'h1C);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0:       rc = 8'hF0;
        1:       rc = 8'hE0;
        2:       rc = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
        default: rc = 8'($urandom);
      endcase
      cyc(($urandom_range(0, 99) == 0), 1'($urandom), rc,
          ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
